// File: rtl/nibble_add_seq.sv
// nibble_add_seq: nibble-serial adder.
//
// One 4-bit gate-level ripple-carry adder (rca) is reused once per cycle.
// Operands are added one nibble at a time, least significant nibble first,
// so an operation takes NIBBLES cycles in RUN plus one cycle in DONE.
//
// Optional feature: define macro SUB_EN to add the 'sub' port. With sub=1
// at acceptance the block computes a - b, and c_out=1 then means no borrow.
//
// Ports (nibble_add_seq):
//   clk    in   1          rising-edge clock
//   rst    in   1          synchronous, active-high reset
//   start  in   1          begin an operation (accepted in IDLE or DONE only)
//   a, b   in   4*NIBBLES  operands
//   c_in   in   1          carry into the least significant nibble
//   sub    in   1          subtract select (only with SUB_EN)
//   busy   out  1          high during the NIBBLES RUN cycles
//   done   out  1          one-cycle pulse when sum/c_out are fresh
//   sum    out  4*NIBBLES  registered result
//   c_out  out  1          registered carry out of the top nibble
//
// Ports (rca): a, b (4 bits), c_in -> sum (4 bits), c_out.

module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  wire [4:0] c;
  wire [3:0] p;
  wire [3:0] g;
  wire [3:0] t;

  assign c[0] = c_in;

  // Classic full-adder cells built from primitives: propagate, generate,
  // and the carry chained from cell to cell.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    xor x_p (p[i], a[i], b[i]);
    xor x_s (sum[i], p[i], c[i]);
    and a_g (g[i], a[i], b[i]);
    and a_t (t[i], p[i], c[i]);
    or  o_c (c[i+1], g[i], t[i]);
  end

  assign c_out = c[4];

endmodule

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
`ifdef SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-5:0]     acc;
  logic [W-1:0]     b_load;
  logic             carry_load;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [W-1:0]     result;

  // Subtraction is a + ~b + 1, so the inversion and the forced carry are
  // applied once when the operands are latched.
`ifdef SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : c_in;
`else
  assign b_load     = b;
  assign carry_load = c_in;
`endif

  // The operand registers shift right each RUN cycle, so the rca always
  // sees the current nibble in bits [3:0].
  rca u_rca (
    .a     (a_r[3:0]),
    .b     (b_r[3:0]),
    .c_in  (carry),
    .sum   (nib_sum),
    .c_out (nib_cout)
  );

  // acc collects finished nibbles from the top down; after the last nibble
  // the rca output plus acc is the complete result.
  assign result = {nib_sum, acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            a_r   <= a;
            b_r   <= b_load;
            carry <= carry_load;
            idx   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_r   <= {4'b0000, a_r[W-1:4]};
          b_r   <= {4'b0000, b_r[W-1:4]};
          carry <= nib_cout;
          acc   <= result[W-1:4];
          // idx only counts cycles; it never touches the data path.
          idx   <= idx + 1'b1;
          if (idx == IDX_W'(NIBBLES - 1)) begin
            state <= DONE;
            sum   <= result;
            c_out <= nib_cout;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an addition.
REQ-005 The block SHALL have port a, input, 4*NIBBLES, first operand.
REQ-006 The block SHALL have port b, input, 4*NIBBLES, second operand.
REQ-007 The block SHALL have port c_in, input, 1, carry into the least significant nibble.
REQ-008 The block SHALL have port sub, input, 1, subtract select; present only when SUB_EN is defined.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port sum, output, 4*NIBBLES, registered result.
REQ-012 The block SHALL have port c_out, output, 1, registered carry out of the most significant nibble.

Function
REQ-013 The block SHALL instantiate the existing 4-bit gate-level rca (ports a, b, c_in, sum, c_out) exactly once, with no behavioural "+" anywhere in the datapath.
REQ-014 The block SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after the last nibble; DONE->IDLE when start=0; DONE->RUN when start=1.
REQ-015 Start SHALL be accepted only in IDLE or DONE; on acceptance a, b and c_in (and sub) are latched, the nibble index is cleared and the carry register loads c_in.
REQ-016 Start asserted in RUN SHALL be ignored, with no effect on the latched operands or the result.
REQ-017 In RUN the block SHALL add one nibble per cycle, LSB first: nibble k of a, nibble k of b and the carry register go into the rca, and the rca carry out is stored for nibble k+1.
REQ-018 busy SHALL be 1 exactly during RUN (NIBBLES cycles) and 0 in IDLE and DONE.
REQ-019 With start sampled high at edge T, done SHALL be 1 for the single cycle following edge T+NIBBLES; total latency is NIBBLES+1 edges.
REQ-020 sum and c_out SHALL update only on the edge entering DONE, and SHALL hold their values until the next completion or reset.
REQ-021 The result SHALL be the modulo-2^(4*NIBBLES) sum of a+b+c_in, with c_out equal to bit 4*NIBBLES of the full sum.
REQ-022 Operand inputs changing while busy SHALL have no effect on the result.
REQ-023 Back-to-back start in DONE SHALL give done pulses exactly NIBBLES+1 cycles apart, without an idle gap.

Reset
REQ-024 While rst=1 at an edge the block SHALL enter IDLE with busy=0, done=0, sum=0, c_out=0, and the nibble index and carry register at 0.
REQ-025 Reset SHALL take priority over start, and reset during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-026 When macro SUB_EN is defined the block SHALL add port sub; with sub=1 at acceptance it computes a - b (b inverted nibble-wise, initial carry forced to 1, c_in ignored), and c_out=1 means no borrow.
REQ-027 When SUB_EN is undefined the block SHALL have no sub port or inversion logic and SHALL always add.

Verification (NIBBLES=4)
REQ-028 The bench SHALL check a=0x1234, b=0x4321, c_in=0, start pulse -> busy for 4 cycles, done one cycle later, sum=0x5555, c_out=0.
REQ-029 The bench SHALL check a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1; and a=0xFFFF, b=0xFFFF, c_in=1 -> sum=0xFFFF, c_out=1.
REQ-030 The bench SHALL check start re-asserted with new operands during RUN -> ignored, first result delivered unchanged.
REQ-031 The bench SHALL check rst asserted in the 2nd RUN cycle -> no done pulse, all outputs 0 on the next cycle, a fresh start then completes correctly.
REQ-032 The bench SHALL check start held high continuously with 0x0001+0x0001 -> done pulses every 5 cycles, sum=0x0002.
REQ-033 With SUB_EN defined, the bench SHALL check sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0; and a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.
